// File: rtl/key_voice_allocator.sv
// Scans pressed-key bitmap edges, assigns keys to synth voices and streams note on/off events.
// Build option VOICE_STEAL_EN: a press with all voices busy steals the oldest voice.
module key_voice_allocator #(
    parameter int unsigned NUM_KEYS   = 32,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = $clog2(NUM_KEYS),
    parameter int unsigned VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_KEYS-1:0]         i_key,
    input  logic                        i_evt_ready,
    output logic                        o_evt_valid,
    output logic                        o_evt_on,
    output logic [KEY_W-1:0]            o_evt_key,
    output logic [VOICE_W-1:0]          o_evt_voice,
    output logic [NUM_VOICES-1:0]       o_voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] o_voice_note,
    output logic                        o_busy
);

`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    localparam logic [VOICE_W-1:0] AGE_MAX  = VOICE_W'(NUM_VOICES - 1);
    localparam logic [KEY_W-1:0]   LAST_KEY = KEY_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        EMIT_OFF = 2'd2,
        EMIT_ON  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NUM_KEYS-1:0]                 held, held_d;
    logic [NUM_KEYS-1:0]                 snap, snap_d;
    logic [KEY_W-1:0]                    idx, idx_d;
    logic [NUM_VOICES-1:0][KEY_W-1:0]    note_q, note_d;
    logic [NUM_VOICES-1:0][VOICE_W-1:0]  age_q, age_d;
    logic [NUM_VOICES-1:0]               active_d;
    logic                                steal_pend, steal_pend_d;
    logic                                evt_valid_d, evt_on_d;
    logic [KEY_W-1:0]                    evt_key_d;
    logic [VOICE_W-1:0]                  evt_voice_d;
    logic                                busy_d;

    logic                                rel_hit, free_hit;
    logic [VOICE_W-1:0]                  rel_v, free_v, old_v, press_v;
    logic [VOICE_W-1:0]                  old_age;
    logic                                key_rel, key_prs, last;
    logic                                do_off, do_on, do_steal;

    assign o_voice_note = note_q;

    // Voice lookup: owner of the scanned key, lowest free voice, oldest voice
    always_comb begin
        rel_hit  = 1'b0;
        rel_v    = '0;
        free_hit = 1'b0;
        free_v   = '0;
        old_v    = '0;
        old_age  = age_q[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (o_voice_active[v] && note_q[v] == idx) begin
                rel_hit = 1'b1;
                rel_v   = VOICE_W'(v);
            end
            if (!free_hit && !o_voice_active[v]) begin
                free_hit = 1'b1;
                free_v   = VOICE_W'(v);
            end
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_v   = VOICE_W'(v);
            end
        end
    end

    assign key_rel  = held[idx] & ~snap[idx];
    assign key_prs  = ~held[idx] & snap[idx];
    assign last     = (idx == LAST_KEY);
    assign do_off   = key_rel & rel_hit;
    assign do_on    = key_prs & free_hit;
    assign do_steal = key_prs & ~free_hit & STEAL_EN;
    assign press_v  = do_on ? free_v : old_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_key != held) state_nxt = SCAN;
            end
            SCAN: begin
                if (do_off || do_steal) state_nxt = EMIT_OFF;
                else if (do_on)         state_nxt = EMIT_ON;
                else if (last)          state_nxt = IDLE;
            end
            EMIT_OFF: begin
                if (i_evt_ready) begin
                    if (steal_pend) state_nxt = EMIT_ON;
                    else if (last)  state_nxt = IDLE;
                    else            state_nxt = SCAN;
                end
            end
            EMIT_ON: begin
                if (i_evt_ready) state_nxt = last ? IDLE : SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values; the voice table changes at decision time, not at event transfer
    always_comb begin
        held_d       = held;
        snap_d       = snap;
        idx_d        = idx;
        active_d     = o_voice_active;
        note_d       = note_q;
        age_d        = age_q;
        steal_pend_d = steal_pend;
        evt_valid_d  = o_evt_valid;
        evt_on_d     = o_evt_on;
        evt_key_d    = o_evt_key;
        evt_voice_d  = o_evt_voice;
        busy_d       = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (i_key != held) begin
                    snap_d = i_key;
                    idx_d  = '0;
                end
            end
            SCAN: begin
                if (key_rel) begin
                    held_d[idx] = 1'b0;
                    if (rel_hit) begin
                        active_d[rel_v] = 1'b0;
                        evt_valid_d     = 1'b1;
                        evt_on_d        = 1'b0;
                        evt_key_d       = idx;
                        evt_voice_d     = rel_v;
                    end
                end else if (key_prs) begin
                    held_d[idx] = 1'b1;
                    if (do_on || do_steal) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (VOICE_W'(v) == press_v)
                                age_d[v] = '0;
                            else if (o_voice_active[v] && age_q[v] != AGE_MAX)
                                age_d[v] = age_q[v] + VOICE_W'(1);
                        end
                        active_d[press_v] = 1'b1;
                        note_d[press_v]   = idx;
                        evt_valid_d       = 1'b1;
                        evt_on_d          = do_on;
                        evt_key_d         = do_on ? idx : note_q[press_v];
                        evt_voice_d       = press_v;
                        steal_pend_d      = do_steal;
                    end
                end
                if (!(do_off || do_on || do_steal)) idx_d = idx + KEY_W'(1);
            end
            EMIT_OFF, EMIT_ON: begin
                if (i_evt_ready) begin
                    if (state == EMIT_OFF && steal_pend) begin
                        steal_pend_d = 1'b0;
                        evt_on_d     = 1'b1;
                        evt_key_d    = idx;
                    end else begin
                        evt_valid_d = 1'b0;
                        idx_d       = idx + KEY_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            held           <= '0;
            snap           <= '0;
            idx            <= '0;
            note_q         <= '0;
            age_q          <= '0;
            o_voice_active <= '0;
            steal_pend     <= 1'b0;
            o_evt_valid    <= 1'b0;
            o_evt_on       <= 1'b0;
            o_evt_key      <= '0;
            o_evt_voice    <= '0;
            o_busy         <= 1'b0;
        end else begin
            held           <= held_d;
            snap           <= snap_d;
            idx            <= idx_d;
            note_q         <= note_d;
            age_q          <= age_d;
            o_voice_active <= active_d;
            steal_pend     <= steal_pend_d;
            o_evt_valid    <= evt_valid_d;
            o_evt_on       <= evt_on_d;
            o_evt_key      <= evt_key_d;
            o_evt_voice    <= evt_voice_d;
            o_busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_key_voice_allocator.sv
// Randomized bench for key_voice_allocator against a key-by-key voice allocation model.
// Honours VOICE_STEAL_EN the same way as the design.
module tb_key_voice_allocator;

    localparam int NK = 32;
    localparam int NV = 4;
    localparam int KW = 5;
    localparam int VW = 2;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NK-1:0]     i_key;
    logic              i_evt_ready;
    logic              o_evt_valid;
    logic              o_evt_on;
    logic [KW-1:0]     o_evt_key;
    logic [VW-1:0]     o_evt_voice;
    logic [NV-1:0]     o_voice_active;
    logic [NV*KW-1:0]  o_voice_note;
    logic              o_busy;

    key_voice_allocator dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key          (i_key),
        .i_evt_ready    (i_evt_ready),
        .o_evt_valid    (o_evt_valid),
        .o_evt_on       (o_evt_on),
        .o_evt_key      (o_evt_key),
        .o_evt_voice    (o_evt_voice),
        .o_voice_active (o_voice_active),
        .o_voice_note   (o_voice_note),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: held keys, per-voice owner and allocation stamp
    logic [NK-1:0] m_held;
    logic [NV-1:0] m_act;
    int            m_note  [NV];
    int            m_stamp [NV];
    int            press_cnt;
    logic [7:0]    exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack_evt(input bit on, input int k, input int v);
        logic [31:0] kk, vv;
        kk = k;
        vv = v;
        return {on, kk[4:0], vv[1:0]};
    endfunction

    task automatic model_reset();
        m_held    = '0;
        m_act     = '0;
        press_cnt = 0;
        for (int v = 0; v < NV; v++) begin
            m_note[v]  = 0;
            m_stamp[v] = 0;
        end
        exp_q.delete();
    endtask

    // Age = voiced presses since this voice was assigned, capped at NV-1
    function automatic int age_of(input int v);
        int a;
        a = press_cnt - m_stamp[v] - 1;
        if (a > NV - 1) a = NV - 1;
        return a;
    endfunction

    task automatic model_apply(input logic [NK-1:0] nk);
        int fv, best, best_age;
        for (int k = 0; k < NK; k++) begin
            if (m_held[k] && !nk[k]) begin
                m_held[k] = 1'b0;
                for (int v = 0; v < NV; v++)
                    if (m_act[v] && m_note[v] == k) begin
                        m_act[v] = 1'b0;
                        exp_q.push_back(pack_evt(1'b0, k, v));
                    end
            end else if (!m_held[k] && nk[k]) begin
                m_held[k] = 1'b1;
                fv = -1;
                for (int v = 0; v < NV; v++)
                    if (fv < 0 && !m_act[v]) fv = v;
                if (fv < 0 && STEAL) begin
                    best = 0;
                    best_age = -1;
                    for (int v = 0; v < NV; v++)
                        if (age_of(v) > best_age) begin
                            best_age = age_of(v);
                            best = v;
                        end
                    exp_q.push_back(pack_evt(1'b0, m_note[best], best));
                    fv = best;
                end
                if (fv >= 0) begin
                    m_act[fv]   = 1'b1;
                    m_note[fv]  = k;
                    m_stamp[fv] = press_cnt;
                    press_cnt++;
                    exp_q.push_back(pack_evt(1'b1, k, fv));
                end
            end
        end
    endtask

    task automatic check_table();
        check("voice_active", 32'(o_voice_active), 32'(m_act));
        for (int v = 0; v < NV; v++)
            if (m_act[v]) check("voice_note", 32'(o_voice_note[v*KW +: KW]), 32'(m_note[v]));
        check("busy_idle", 32'(o_busy), 32'(0));
    endtask

    task automatic apply(input logic [NK-1:0] nk);
        model_apply(nk);
        i_key = nk;
    endtask

    // Consume events until model queue is empty and DUT is idle; stall = cycles of ready low while valid
    task automatic drain(input int stall, input bit rnd);
        int         cyc;
        bit         pv, v, rdy;
        logic [7:0] pe, e;
        cyc = 0;
        pv  = 1'b0;
        pe  = '0;
        while (cyc < 4000) begin
            if (pv) check("hold_stable", 32'({o_evt_valid, o_evt_on, o_evt_key, o_evt_voice}), 32'({1'b1, pe}));
            v = o_evt_valid;
            e = {o_evt_on, o_evt_key, o_evt_voice};
            if (v && stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            i_evt_ready = rdy;
            @(posedge i_clk);
            #1;
            cyc++;
            if (v && rdy) begin
                if (exp_q.size() == 0) check("extra_evt", 32'(e), 32'hFFFF_FFFF);
                else check("evt", 32'(e), 32'(exp_q.pop_front()));
            end
            pv = v && !rdy;
            pe = e;
            if (cyc >= 3 && exp_q.size() == 0 && !o_busy && !o_evt_valid) break;
        end
        check("drain_done", 32'({exp_q.size() == 0, o_busy}), 32'(2'b10));
        exp_q.delete();
        i_evt_ready = 1'b1;
        check_table();
    endtask

    // Single-key change from idle: valid must rise 2+k edges after the change
    task automatic latency(input logic [NK-1:0] nk, input int k);
        int cyc;
        cyc = 0;
        i_evt_ready = 1'b1;
        apply(nk);
        while (!o_evt_valid && cyc < 200) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(2 + k));
        check("table_before_ack", 32'(o_voice_active), 32'(m_act));
        drain(0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({o_evt_valid, o_evt_on, o_evt_key, o_evt_voice, o_busy}), 32'(0));
        check(tag, 32'(o_voice_active), 32'(0));
        check(tag, o_voice_note, 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NK-1:0] cur, nk;
        int flips;
        i_rst       = 1'b1;
        i_key       = 32'hFFFF_FFFF;
        i_evt_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset_outputs");

        // Release reset with every key held
        i_rst = 1'b0;
        i_evt_ready = 1'b1;
        model_apply(32'hFFFF_FFFF);
        drain(0, 1'b0);
        apply('0);
        drain(0, 1'b0);

        latency(32'h0000_0001, 0);
        check("note0", 32'(o_voice_note[KW-1:0]), 32'(0));
        apply('0);
        drain(0, 1'b0);
        latency(32'h0000_2000, 13);
        apply('0);
        drain(0, 1'b0);

        // Keys 3,5,7 together, then release 5
        apply(32'h0000_00A8);
        drain(0, 1'b1);
        apply(32'h0000_0088);
        drain(0, 1'b1);
        check("tbl_357", 32'(o_voice_active), 32'(4'b0101));
        apply('0);
        drain(0, 1'b0);

        // Back-pressure on a single note-on
        apply(32'h0000_0200);
        drain(10, 1'b0);
        apply('0);
        drain(0, 1'b0);

        // Five keys with four voices, then release key 4
        apply(32'h0000_001F);
        drain(0, 1'b0);
        apply(32'h0000_000F);
        drain(0, 1'b0);
        apply('0);
        drain(0, 1'b0);

        // Release of key 2 frees a voice for key 20 in the same scan
        apply(32'h0000_000F);
        drain(0, 1'b0);
        apply(32'h0010_000B);
        drain(0, 1'b1);
        apply('0);
        drain(0, 1'b0);

        // Reset in the middle of a scan
        i_key = 32'h0000_F0F0;
        repeat (7) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("midscan_reset");
        @(posedge i_clk);
        #1;
        i_key = '0;
        i_rst = 1'b0;
        model_reset();
        drain(0, 1'b0);

        cur = '0;
        for (int it = 0; it < 60; it++) begin
            nk = cur;
            flips = $urandom_range(1, 5);
            for (int j = 0; j < flips; j++) begin
                int b;
                b = $urandom_range(0, NK - 1);
                nk[b] = ~nk[b];
            end
            if (it % 15 == 7) nk = $urandom();
            apply(nk);
            cur = nk;
            drain($urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
